// File: rtl/seg7_pkg.sv
// Shared constants and the hex glyph table for the four-digit common-anode
// 7-segment scanner. All segment values are active-low.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK   = 8'hFF;
    localparam logic [3:0] ANODE_OFF   = 4'hF;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    // Bit order g,f,e,d,c,b,a; index is the hex value shown.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder with a blank override, used on the
// digit currently selected by the scanner.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? GLYPH_BLANK : hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed hex display with frame-boundary shadow capture.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 never blanks).
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DIV_BITS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] num,
    input  logic [3:0]  dp,
    output logic [7:0]  segment,
    output logic [3:0]  anode
);

    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [15:0]         num_sh_q, num_sh_d;
    logic [3:0]          dp_sh_q, dp_sh_d;
    logic [7:0]          segment_q, segment_d;
    logic [3:0]          anode_q, anode_d;

    logic       digit_end;
    logic       frame_end;
    logic [3:0] cur_nibble;
    logic       cur_blank;
    logic [6:0] cur_glyph;

    assign digit_end  = &cnt_q;
    assign frame_end  = digit_end && (idx_q == 2'd3);
    assign cur_nibble = num_sh_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit blanks only when it and every digit to its left are zero.
    always_comb begin
        cur_blank = 1'b0;
        unique case (idx_q)
            2'd3:    cur_blank = ~|num_sh_q[15:12];
            2'd2:    cur_blank = ~|num_sh_q[15:8];
            2'd1:    cur_blank = ~|num_sh_q[15:4];
            default: cur_blank = 1'b0;
        endcase
    end
`else
    assign cur_blank = 1'b0;
`endif

    seg7_decode u_decode (
        .nibble_i (cur_nibble),
        .blank_i  (cur_blank),
        .seg_o    (cur_glyph)
    );

    // NOTE: every output is assigned a default before any condition, so no latch can form.
    always_comb begin
        cnt_d     = cnt_q + DIV_BITS'(1);
        idx_d     = digit_end ? idx_q + 2'd1 : idx_q;
        num_sh_d  = frame_end ? num : num_sh_q;
        dp_sh_d   = frame_end ? dp  : dp_sh_q;
        anode_d   = ~(4'b0001 << idx_q);
        segment_d = {~dp_sh_q[idx_q], cur_glyph};
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            num_sh_q  <= 16'h0000;
            dp_sh_q   <= 4'h0;
            segment_q <= SEG_BLANK;
            anode_q   <= ANODE_OFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            num_sh_q  <= num_sh_d;
            dp_sh_q   <= dp_sh_d;
            segment_q <= segment_d;
            anode_q   <= anode_d;
        end
    end

    assign segment = segment_q;
    assign anode   = anode_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a frame-level reference model pushes
// the expected pins per clock edge, a negedge monitor pops and compares.
module tb_seg7_scan_display;

    localparam int DIV_BITS   = 2;
    localparam int DIGIT_CLKS = 1 << DIV_BITS;
    localparam int FRAME_CLKS = 4 * DIGIT_CLKS;
    localparam int HIST_LEN   = 8192;

    localparam logic [6:0] GLYPH_REF [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [7:0]  seg;
        logic [3:0]  an;
        logic [31:0] edge_no;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] num   = 16'h0000;
    logic [3:0]  dp    = 4'h0;
    logic [7:0]  segment;
    logic [3:0]  anode;

    exp_t        exp_q[$];
    logic [15:0] num_hist [HIST_LEN];
    logic [3:0]  dp_hist  [HIST_LEN];
    int          n      = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    seg7_scan_display #(.DIV_BITS(DIV_BITS)) dut (
        .clock   (clock),
        .reset   (reset),
        .num     (num),
        .dp      (dp),
        .segment (segment),
        .anode   (anode)
    );

    // Expected pins after post-reset edge number edge_no, given the value on display.
    function automatic exp_t predict(input int edge_no, input logic [15:0] shown,
                                     input logic [3:0] dps);
        exp_t       e;
        int         digit;
        logic [3:0] nib;
        logic [6:0] glyph;
        digit = ((edge_no - 1) / DIGIT_CLKS) % 4;
        nib   = shown[4*digit +: 4];
        glyph = GLYPH_REF[nib];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (digit != 0 && (shown >> (4 * digit)) == 16'h0000) glyph = 7'h7F;
`endif
        e.seg        = {~dps[digit], glyph};
        e.an         = 4'hF;
        e.an[digit]  = 1'b0;
        e.edge_no    = edge_no;
        return e;
    endfunction

    // Reference model: inputs are captured at the last edge of each frame and
    // shown through the whole following frame; before the first capture the value is zero.
    always @(posedge clock) begin
        exp_t e;
        int   load_edge;
        if (reset) begin
            n = 0;
            e = '{seg: 8'hFF, an: 4'hF, edge_no: 32'd0};
        end else begin
            n = n + 1;
            if (n < HIST_LEN) begin
                num_hist[n] = num;
                dp_hist[n]  = dp;
            end
            load_edge = FRAME_CLKS * ((n - 1) / FRAME_CLKS);
            if (load_edge == 0)
                e = predict(n, 16'h0000, 4'h0);
            else
                e = predict(n, num_hist[load_edge], dp_hist[load_edge]);
        end
        exp_q.push_back(e);
    end

    initial begin : monitor
        exp_t e;
        @(posedge clock);
        forever begin
            @(negedge clock);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: DUT segment=%h anode=%b with no expectation queued",
                         segment, anode);
            end else begin
                e = exp_q.pop_front();
                if (segment !== e.seg || anode !== e.an) begin
                    errors++;
                    $display("FAIL edge_%0d: got segment=%h anode=%b, expected segment=%h anode=%b",
                             e.edge_no, segment, anode, e.seg, e.an);
                end
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clock);
    endtask

    initial begin : stimulus
        int sel;
        // Reset for 3 clocks with 12AF waiting; it appears in the frame from edge 17.
        num   = 16'h12AF;
        dp    = 4'h0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(36);

        // 1111 loads at edge 48; 2222 arrives mid digit 2 of the 1111 frame.
        num = 16'h1111;
        tick(22);
        num = 16'h2222;
        tick(30);

        // Decimal point on digit 2 only.
        num = 16'h8888;
        dp  = 4'b0100;
        tick(32);

        // Reset while digit 2 is being scanned, then restart from digit 0 showing 0.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        dp    = 4'h0;
        tick(20);

        // Leading-zero patterns.
        num = 16'h0000;
        tick(36);
        num = 16'h00A0;
        tick(36);
        num = 16'h0F00;
        dp  = 4'b1001;
        tick(36);

        // Randomized values, hold times and occasional resets.
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 3));
            num = 16'($urandom);
            case (sel)
                1:       num = num & 16'h00FF;
                2:       num = num & 16'h000F;
                3:       num = num & 16'h0FFF;
                default: ;
            endcase
            dp = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b1;
                tick(int'($urandom_range(1, 3)));
                reset = 1'b0;
            end
            tick(int'($urandom_range(1, 24)));
        end
        tick(40);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
